// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FIFO payload pairs each fetched word with the PC it came from.
package instr_fetch_pkg;

    localparam int WD_INSTR = 32;
    localparam int WD_PC    = 32;

    localparam logic [WD_INSTR-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        HOLD,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [WD_INSTR-1:0] instr;
        logic [WD_PC-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus: request/grant on the way out, in-order read data on the way back.
interface instr_fetch_if #(
    parameter int WD_PC    = 32,
    parameter int WD_INSTR = 32
);

    logic                req;
    logic [WD_PC-1:0]    addr;
    logic                gnt;
    logic                rvalid;
    logic [WD_INSTR-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a combinational head.
// Flush wins over push and pop so a redirect always leaves the buffer empty.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && !i_flush && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word fetches and buffers responses for decode.
// A redirect reloads the PC, flushes the buffer and counts off responses still owed by memory.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                   wd_instr_p   = WD_INSTR,
    parameter int                   wd_pc_p      = WD_PC,
    parameter logic [wd_pc_p-1:0]   reset_pc_p   = '0,
    parameter int                   fifo_depth_p = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_if.master         imem,
    input  logic                  i_redirect_valid,
    input  logic [wd_pc_p-1:0]    i_redirect_pc,
    output logic                  o_instr_valid,
    output logic [wd_instr_p-1:0] o_instr,
    output logic [wd_pc_p-1:0]    o_instr_pc,
    input  logic                  i_instr_ready
);

    localparam int CW = $clog2(fifo_depth_p) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [wd_pc_p-1:0] r_pc;
    logic [wd_pc_p-1:0] w_pc_next;
    logic [wd_pc_p-1:0] r_resp_pc;
    logic [wd_pc_p-1:0] w_resp_pc_next;
    logic [CW-1:0]      r_out_cnt;
    logic [CW-1:0]      w_out_cnt_next;
    logic [CW-1:0]      r_discard_cnt;
    logic [CW-1:0]      w_discard_next;

    logic [wd_pc_p-1:0] w_redirect_aligned;
    logic               w_req;
    logic               w_fire;
    logic               w_rsp;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [CW-1:0]      w_fifo_cnt;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    assign w_redirect_aligned = i_redirect_pc & ~wd_pc_p'(3);

    // Credit: words in flight plus words buffered may never exceed the FIFO depth.
    assign w_req  = (r_state == FETCH) && !i_redirect_valid &&
                    (((CW+1)'(r_out_cnt) + (CW+1)'(w_fifo_cnt)) < (CW+1)'(fifo_depth_p));
    assign w_fire = w_req && imem.gnt;

    // A response with nothing outstanding is ignored so the counters cannot underflow.
    assign w_rsp  = imem.rvalid && (r_out_cnt != '0);
    assign w_push = w_rsp && (r_discard_cnt == '0) && !i_redirect_valid;
    assign w_pop  = o_instr_valid && i_instr_ready;

    assign w_push_entry = {imem.rdata, r_resp_pc};

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_resp_pc_next = r_resp_pc;
        w_out_cnt_next = r_out_cnt + CW'(w_fire) - CW'(w_rsp);
        w_discard_next = r_discard_cnt;

        if (i_redirect_valid) begin
            w_pc_next      = w_redirect_aligned;
            w_resp_pc_next = w_redirect_aligned;
            w_discard_next = r_out_cnt - CW'(w_rsp);
        end else begin
            if (w_fire) begin
                w_pc_next = r_pc + wd_pc_p'(4);
            end
            if (w_push) begin
                w_resp_pc_next = r_resp_pc + wd_pc_p'(4);
            end
            if (w_rsp && (r_discard_cnt != '0)) begin
                w_discard_next = r_discard_cnt - CW'(1);
            end
        end

        case (r_state)
            HOLD: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (i_redirect_valid && (w_discard_next != '0)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_discard_next == '0) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HOLD;
            r_pc          <= reset_pc_p;
            r_resp_pc     <= reset_pc_p;
            r_out_cnt     <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_resp_pc     <= w_resp_pc_next;
            r_out_cnt     <= w_out_cnt_next;
            r_discard_cnt <= w_discard_next;
        end
    end

    instr_fetch_fifo #(
        .DEPTH (fifo_depth_p)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (i_redirect_valid),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    assign o_instr_valid = !w_fifo_empty && !i_redirect_valid;
    assign o_instr       = w_fifo_empty ? NOP_INSTR : w_head.instr;
    assign o_instr_pc    = w_fifo_empty ? '0 : w_head.pc;

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.rvalid && (r_out_cnt == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_fifo_full && !w_pop));
    a_out_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (r_out_cnt <= CW'(fifo_depth_p)));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: an in-order memory responder plus a reference of the
// architectural fetch/delivery PC streams, with directed phases for the corner cases.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_if #(.WD_PC(32), .WD_INSTR(32)) imem_bus ();

    instr_fetch #(
        .wd_instr_p   (32),
        .wd_pc_p      (32),
        .reset_pc_p   (32'h0),
        .fifo_depth_p (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem_bus),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_instr_valid    (instr_valid),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc),
        .i_instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          cyc;
    } pend_t;

    pend_t       pend_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    logic [31:0] exp_fetch, exp_pc;
    int          gnt_pct, rv_pct, rdy_pct, redir_pct;
    int          n_grants, n_pops, first_gnt_cyc, first_valid_cyc;
    logic [31:0] last_gnt_addr, last_pop_pc;
    logic        s_req, s_valid, s_rv;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i].stale) n++;
        return n;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_req"},   32'(imem_bus.req), 32'd0);
        check_value({tag, "_valid"}, 32'(instr_valid),  32'd0);
        check_value({tag, "_instr"}, instr,             NOP_INSTR);
        check_value({tag, "_pc"},    instr_pc,          32'd0);
    endtask

    // Reset either cleanly at a falling edge or asynchronously just after a rising edge.
    task automatic do_reset(input bit async_mid);
        if (async_mid) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
        end else begin
            @(negedge clk);
            rst_n = 1'b0;
        end
        #1;
        check_reset_outputs(async_mid ? "async_reset" : "reset");
        @(negedge clk);
        redirect_valid  = 1'b0;
        imem_bus.gnt    = 1'b1;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        instr_ready     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("hold_no_req", 32'(imem_bus.req), 32'd0);
        pend_q.delete();
        exp_fetch       = 32'h0;
        exp_pc          = 32'h0;
        n_grants        = 0;
        n_pops          = 0;
        first_gnt_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive inputs at the falling edge, sample and score 1 ns later.
    task automatic step(input bit force_redir, input logic [31:0] force_pc);
        bit redir;
        bit rv;
        @(negedge clk);
        cyc++;
        redir = force_redir || ($urandom_range(99) < redir_pct);
        redirect_valid = redir;
        redirect_pc = force_redir ? force_pc :
                      (($urandom_range(7) == 0) ? 32'hFFFF_FFFD : $urandom);
        rv = 1'b0;
        if (pend_q.size() > 0) begin
            if (pend_q[0].cyc < cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
        end
        imem_bus.rvalid = rv;
        imem_bus.rdata  = rv ? mem_word(pend_q[0].addr) : $urandom;
        imem_bus.gnt    = ($urandom_range(99) < gnt_pct);
        instr_ready     = ($urandom_range(99) < rdy_pct);
        #1;
        s_req   = imem_bus.req;
        s_addr  = imem_bus.addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_rv    = rv;

        if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (redir) begin
            check_value("req_in_redirect",   32'(s_req),   32'd0);
            check_value("valid_in_redirect", 32'(s_valid), 32'd0);
        end
        if (s_req && imem_bus.gnt) begin
            check_value("fetch_addr", s_addr, exp_fetch);
            check_value("stale_owed_at_gnt", 32'(stale_count()), 32'd0);
            check_value("outstanding_bound", 32'(pend_q.size() < DEPTH), 32'd1);
            pend_q.push_back('{addr: s_addr, stale: 1'b0, cyc: cyc});
            exp_fetch = exp_fetch + 32'd4;
            n_grants++;
            last_gnt_addr = s_addr;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end
        if (s_valid && instr_ready) begin
            check_value("instr_pc", s_pc, exp_pc);
            check_value("instr_word", s_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
            last_pop_pc = s_pc;
        end
        if (rv) void'(pend_q.pop_front());
        if (redir) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic set_rates(input int g, input int r, input int d, input int x);
        gnt_pct   = g;
        rv_pct    = r;
        rdy_pct   = d;
        redir_pct = x;
    endtask

    initial begin
        int g0;
        int p0;
        int k;
        logic [31:0] held_addr;

        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        set_rates(100, 100, 100, 0);

        // Streaming from reset: addresses 0,4,8.. and two-cycle gnt-to-valid latency.
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
        check_value("first_valid_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
        check_value("stream_progress", 32'(n_pops >= 5), 32'd1);

        // Decode stalled: credit stops requests once two words are held.
        do_reset(1'b0);
        set_rates(100, 100, 0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check_value("grants_while_stalled", 32'(n_grants), 32'd2);
        check_value("stalled_req", 32'(s_req), 32'd0);
        check_value("stalled_valid", 32'(s_valid), 32'd1);
        check_value("stalled_head_pc", s_pc, 32'h0);
        set_rates(100, 100, 100, 0);
        for (k = 0; k < 10 && n_grants < 3; k++) step(1'b0, 32'h0);
        check_value("resume_addr", last_gnt_addr, 32'h8);

        // Redirect with two responses owed: both dropped before fetching from 0x100.
        do_reset(1'b0);
        set_rates(100, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
        check_value("owed_before_redirect", 32'(pend_q.size()), 32'd2);
        step(1'b1, 32'h103);
        set_rates(100, 100, 100, 0);
        g0 = n_grants;
        for (k = 0; k < 20 && n_grants == g0; k++) step(1'b0, 32'h0);
        check_value("redirect_first_addr", last_gnt_addr, 32'h100);
        p0 = n_pops;
        for (k = 0; k < 20 && n_pops == p0; k++) step(1'b0, 32'h0);
        check_value("redirect_first_pop", last_pop_pc, 32'h100);

        // Redirect together with a response and a ready decode.
        do_reset(1'b0);
        set_rates(100, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
        set_rates(100, 100, 0, 0);
        step(1'b0, 32'h0);
        set_rates(100, 100, 100, 0);
        step(1'b1, 32'h40);
        check_value("rv_in_redirect", 32'(s_rv), 32'd1);
        step(1'b0, 32'h0);
        check_value("flushed_valid", 32'(s_valid), 32'd0);
        check_value("no_discard_left_req", 32'(s_req), 32'd1);
        check_value("no_discard_left_addr", s_addr, 32'h40);

        // Grant withheld: address stays put; then the PC wraps past the top of memory.
        do_reset(1'b0);
        set_rates(0, 100, 100, 0);
        step(1'b1, 32'hFFFF_FFFF);
        held_addr = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            check_value("held_req", 32'(s_req), 32'd1);
            check_value("held_addr", s_addr, held_addr);
        end
        set_rates(100, 100, 100, 0);
        g0 = n_grants;
        for (k = 0; k < 20 && n_grants < g0 + 2; k++) step(1'b0, 32'h0);
        check_value("wrap_addr", last_gnt_addr, 32'h0);

        // Random traffic, then an asynchronous reset in the middle of it.
        set_rates(70, 60, 70, 0);
        for (int i = 0; i < 200; i++) step(1'b0, 32'h0);
        do_reset(1'b1);

        // Long random run with redirects.
        set_rates(70, 60, 70, 4);
        for (int i = 0; i < 3000; i++) step(1'b0, 32'h0);
        check_value("random_progress", 32'(n_pops > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
